// File: rtl/proc_run_ctrl.sv
// rtl/proc_run_ctrl.sv - host run controller: preload data memory, reset core, run with timeout, report
// Drives the core's reset/req and times execution until done or TIMEOUT.
module proc_run_ctrl #(
  parameter int AW      = 8,
  parameter int CW      = 16,
  parameter int TIMEOUT = 4095,
  parameter int RST_CYC = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] load_len,
  input  logic          ld_valid,
  input  logic [7:0]    ld_data,
  output logic          ld_ready,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_dat,
  output logic          core_reset,
  output logic          core_req,
  input  logic          core_done,
  output logic          busy,
  output logic          rpt_valid,
  output logic [CW-1:0] cycles,
  output logic          timed_out
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RESET_CORE, S_RUN, S_REPORT} state_t;

  localparam int            RW       = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYC - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] len_q, len_d, addr_q, addr_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [CW-1:0] cnt_q, cnt_d, cycles_q, cycles_d;
  logic          timed_out_q, timed_out_d;
  logic          wr, load_last;

  assign wr        = ld_valid & ld_ready;
  assign load_last = wr && (addr_q == len_q - AW'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (start) state_d = (load_len != '0) ? S_LOAD : S_RESET_CORE;
      S_LOAD:       if (load_last) state_d = S_RESET_CORE;
      S_RESET_CORE: if (rcnt_q == RST_LAST) state_d = S_RUN;
      S_RUN:        if (core_done || (cnt_q == TO_LAST)) state_d = S_REPORT;
      S_REPORT:     state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ld_ready   = 1'b0;
    core_reset = 1'b1;
    core_req   = 1'b0;
    busy       = 1'b1;
    rpt_valid  = 1'b0;
    case (state_q)
      S_IDLE:   busy = 1'b0;
      S_LOAD:   ld_ready = 1'b1;
      S_RUN: begin
        core_reset = 1'b0;
        core_req   = 1'b1;
      end
      S_REPORT: rpt_valid = 1'b1;
      default:  ;
    endcase
  end

  // Counters are zeroed at start acceptance, so entry into RESET_CORE and RUN sees zero.
  always_comb begin
    len_d       = len_q;
    addr_d      = addr_q;
    rcnt_d      = rcnt_q;
    cnt_d       = cnt_q;
    cycles_d    = cycles_q;
    timed_out_d = timed_out_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d       = load_len;
          addr_d      = '0;
          rcnt_d      = '0;
          cnt_d       = '0;
          cycles_d    = '0;
          timed_out_d = 1'b0;
        end
      end
      S_LOAD:       if (wr) addr_d = addr_q + AW'(1);
      S_RESET_CORE: rcnt_d = rcnt_q + RW'(1);
      S_RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (core_done) begin
          cycles_d    = cnt_q + CW'(1);
          timed_out_d = 1'b0;
        end else if (cnt_q == TO_LAST) begin
          cycles_d    = CW'(TIMEOUT);
          timed_out_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q       <= '0;
      addr_q      <= '0;
      rcnt_q      <= '0;
      cnt_q       <= '0;
      cycles_q    <= '0;
      timed_out_q <= 1'b0;
    end else begin
      len_q       <= len_d;
      addr_q      <= addr_d;
      rcnt_q      <= rcnt_d;
      cnt_q       <= cnt_d;
      cycles_q    <= cycles_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign mem_wr_en = wr;
  assign mem_addr  = addr_q;
  assign mem_dat   = ld_data;
  assign cycles    = cycles_q;
  assign timed_out = timed_out_q;

endmodule

// File: doc/proc_run_ctrl.md
# proc_run_ctrl

Host-side run controller that sits directly upstream of the processor top level and drives its `reset`/`req` inputs while watching its `done` output. On a host `start`, it streams a preload image into data memory through a valid/ready port, then holds the core in reset for a fixed number of cycles. It releases the core with `req` high, counts execution cycles until `done` or a timeout, and posts a one-cycle report. Testbenches and any future multi-program sequencer talk to the core only through this block.

## Interface
- `AW`, 8, data-memory address width; preload length 0..2^AW-1 bytes
- `CW`, 16, cycle-counter width; must satisfy TIMEOUT <= 2^CW-1
- `TIMEOUT`, 4095, maximum RUN cycles before abort; legal range 1..2^CW-1
- `RST_CYC`, 2, cycles `core_reset` is held in RESET_CORE; must be >= 1

- `clk`  in  1  single clock; all state on rising edge
- `reset`  in  1  asynchronous, active-low; all flops clear immediately on assertion
- `start`  in  1  request a run; sampled only in IDLE
- `load_len`  in  AW  preload byte count; captured with `start`
- `ld_valid`  in  1  preload byte available
- `ld_data`  in  8  preload byte
- `ld_ready`  out  1  high only in LOAD
- `mem_wr_en`  out  1  data-memory write strobe = `ld_valid & ld_ready`
- `mem_addr`  out  AW  preload address counter
- `mem_dat`  out  8  equals `ld_data`
- `core_reset`  out  1  active-high reset to the processor
- `core_req`  out  1  high throughout RUN
- `core_done`  in  1  processor done; combinational from the core
- `busy`  out  1  high from the cycle after `start` acceptance through REPORT
- `rpt_valid`  out  1  one-cycle pulse in REPORT
- `cycles`  out  CW  RUN-cycle count of last run; held until next `start`
- `timed_out`  out  1  last run aborted by timeout; held until next `start`

## Operation
- States: IDLE, LOAD, RESET_CORE, RUN, REPORT. Reset value: IDLE.
- After `reset`, all outputs are 0 except `core_reset`, which is 1. `cycles`, `timed_out` and all counters are 0.
- **IDLE**
  - Outputs: `core_reset`=1, `busy`=0.
  - `start`=1 captures `load_len`, clears `cycles` and `timed_out`, and zeroes the address counter.
  - Next state: LOAD if `load_len` != 0, else RESET_CORE.
- **LOAD**
  - Outputs: `ld_ready`=1, `core_reset`=1.
  - Each handshake writes `ld_data` to `mem_addr` in the same cycle, then the address counter increments.
  - `ld_valid`=0 stalls with no write.
  - After the `load_len`th handshake, go to RESET_CORE. The address counter never wraps because `load_len` <= 2^AW-1.
- **RESET_CORE**
  - `core_reset`=1 for exactly RST_CYC cycles, counted by a local counter, then go to RUN.
- **RUN**
  - `core_reset`=0, `core_req`=1. The cycle counter starts at 0 on entry and increments every RUN cycle.
  - If `core_done`=1: `cycles` <= cnt+1, `timed_out` <= 0, go to REPORT.
  - Else if cnt+1 == TIMEOUT: `cycles` <= TIMEOUT, `timed_out` <= 1, go to REPORT.
  - If `core_done` and the timeout condition occur in the same cycle, done wins and `timed_out`=0.
- **REPORT**
  - Outputs: `rpt_valid`=1, `busy`=1, `core_reset`=1, `core_req`=0. Next state: IDLE.
- Ignored inputs:
  - `start` outside IDLE.
  - `ld_valid` outside LOAD; `ld_ready` is 0 there.
  - `core_done` outside RUN.
- Asserting `reset` mid-run returns to IDLE immediately. A partial preload is abandoned, no report is produced, and `core_reset` goes to 1 asynchronously.

## Timing
- `start` accepted at edge t: `busy`=1 and state LOAD/RESET_CORE from cycle t+1.
- Preload with `ld_valid` held high: writes occur in cycles t+1..t+N.
- RESET_CORE occupies the next RST_CYC cycles. The first RUN cycle is t+N+RST_CYC+1.
- Done seen in RUN cycle k (k=0 first) gives `cycles`=k+1. REPORT is the following cycle, then IDLE. `busy` falls the cycle after REPORT.
- Back-to-back runs: `start` held high is accepted the first IDLE cycle after REPORT. The minimum gap between reports is N+RST_CYC+3 cycles.
- Writes are combinational with the handshake: zero latency from `ld_valid` to `mem_wr_en`.
- `cycles` and `timed_out` update at the REPORT-entry edge. They are stable while `rpt_valid` is high.

## Test plan
- Reset, then `start` with `load_len`=0, core model raising `core_done` on its 5th RUN cycle -> RESET_CORE for 2 cycles, then RUN. `rpt_valid` pulses once with `cycles`=5 and `timed_out`=0.
- `load_len`=4, bytes 0x11,0x22,0x33,0x44, with `ld_valid` dropped for 2 cycles after byte 2 -> exactly 4 writes, to addr 0..3 with the matching data. LOAD lasts 6 cycles and no write occurs during the stall.
- TIMEOUT=10 and `core_done` never asserted -> exactly 10 RUN cycles, then `cycles`=10 and `timed_out`=1. `core_reset` is back to 1 in REPORT.
- TIMEOUT=10 with `core_done` asserted on RUN cycle 9 (the 10th) -> `cycles`=10 and `timed_out`=0, because done wins.
- `start` pulsed during LOAD and RUN, and `ld_valid`/`core_done` toggled in IDLE -> no state change, no writes and no report. `ld_ready` stays 0 outside LOAD.
- `reset` asserted mid-LOAD after 2 of 4 bytes -> IDLE with `core_reset`=1 and `busy`=0 asynchronously. A fresh `start` with `load_len`=4 rewrites from addr 0.
